// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 exception unit: holds SR (12), Cause (13), EPC (14) and PRId (15).
// Raises a single combinational Req that flushes the pipeline and redirects fetch
// to the handler, captures the victim state, and serves mfc0/mtc0 from MEM.
//
// Ports:
//   clk, reset    clock, synchronous active-low reset
//   A1            mfc0 read register number
//   A2, Din, WE   mtc0 write register number, data, enable
//   VPC, BDIn     victim PC and branch-delay-slot flag
//   ExcCodeIn     victim exception code (0 = none)
//   HWInt         level-sensitive hardware interrupt lines
//   EXLClr        eret committing this cycle
//   Dout          combinational mfc0 read data
//   EPCOut        eret target, with bypass of an in-flight mtc0 EPC
//   Req           combinational exception/interrupt request
module cp0_exception_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h0000_7c07,
  parameter logic [5:0]  IM_RESET   = 6'b000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] Din,
  input  logic        WE,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] Dout,
  output logic [31:0] EPCOut,
  output logic        Req
);

  logic [5:0]  sr_im_q;
  logic        sr_exl_q;
  logic        sr_ie_q;
  logic        cause_bd_q;
  logic [5:0]  cause_ip_q;
  logic [4:0]  cause_exc_q;
  logic [31:2] epc_q;

  logic        int_req;
  logic        exc_req;
  logic [31:0] victim_pc;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic [31:0] epc_word;
  logic        wr_sr;
  logic        wr_epc;
  logic        unused_bits;

  always_comb begin
    int_req   = (|(HWInt & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    exc_req   = (ExcCodeIn != 5'd0) & ~sr_exl_q;
    Req       = int_req | exc_req;
    // A victim in a delay slot restarts at its branch.
    victim_pc = BDIn ? (VPC - 32'd4) : VPC;
    wr_sr     = WE && (A2 == 5'd12);
    wr_epc    = WE && (A2 == 5'd14);
  end

  assign unused_bits = ^victim_pc[1:0];

  always_comb begin
    sr_word    = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
    cause_word = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
    epc_word   = {epc_q, 2'b00};
    case (A1)
      5'd12:   Dout = sr_word;
      5'd13:   Dout = cause_word;
      5'd14:   Dout = epc_word;
      5'd15:   Dout = PRID_VALUE;
      default: Dout = 32'd0;
    endcase
    // Bypass lets an eret in ID see an mtc0 EPC still sitting in MEM.
    EPCOut = wr_epc ? {Din[31:2], 2'b00} : epc_word;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_im_q     <= IM_RESET;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= 6'd0;
      cause_exc_q <= 5'd0;
      epc_q       <= 30'd0;
    end else begin
      cause_ip_q <= HWInt;
      if (Req) begin
        // The victim is squashed, so any same-cycle mtc0 or eret is dropped.
        sr_exl_q    <= 1'b1;
        cause_bd_q  <= BDIn;
        cause_exc_q <= int_req ? 5'd0 : ExcCodeIn;
        epc_q       <= victim_pc[31:2];
      end else begin
        if (wr_sr) begin
          sr_im_q  <= Din[15:10];
          sr_exl_q <= Din[1];
          sr_ie_q  <= Din[0];
        end
        if (wr_epc) begin
          epc_q <= Din[31:2];
        end
        // Placed after the mtc0 so eret clears EXL over a same-cycle SR write.
        if (EXLClr) begin
          sr_exl_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_exception_unit.sv
module tb_cp0_exception_unit;

  localparam logic [31:0] PRID = 32'h0000_7c07;

  logic        clk;
  logic        reset;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [31:0] din;
  logic        we;
  logic [31:0] vpc;
  logic        bd;
  logic [4:0]  exc;
  logic [5:0]  hw;
  logic        clr;
  logic [31:0] dout;
  logic [31:0] epc_out;
  logic        req;

  cp0_exception_unit #(
    .PRID_VALUE(PRID),
    .IM_RESET  (6'b000000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .A1       (a1),
    .A2       (a2),
    .Din      (din),
    .WE       (we),
    .VPC      (vpc),
    .BDIn     (bd),
    .ExcCodeIn(exc),
    .HWInt    (hw),
    .EXLClr   (clr),
    .Dout     (dout),
    .EPCOut   (epc_out),
    .Req      (req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] dout;
    logic [31:0] epc_out;
    int          lit_sel;  // 0 none, 1 Dout literal, 2 EPCOut literal
    logic [31:0] lit;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  // Architectural view of the CP0 registers as plain 32-bit words.
  logic [31:0] m_sr = 32'd0;
  logic [31:0] m_cause = 32'd0;
  logic [31:0] m_epc = 32'd0;

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    logic        ireq;
    logic        ereq;
    logic [31:0] nsr;
    logic [31:0] ncause;
    logic [31:0] nepc;
    if (!reset) begin
      m_sr    = 32'd0;
      m_cause = 32'd0;
      m_epc   = 32'd0;
      return;
    end
    ireq   = ((hw & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    ereq   = (exc != 5'd0) && !m_sr[1];
    nsr    = m_sr;
    nepc   = m_epc;
    ncause = (m_cause & ~32'h0000_fc00) | ({26'd0, hw} << 10);
    if (ireq || ereq) begin
      nsr    = nsr | 32'h2;
      ncause = (ncause & 32'h0000_fc00) | ({31'd0, bd} << 31)
               | ({27'd0, (ireq ? 5'd0 : exc)} << 2);
      nepc   = (bd ? vpc - 32'd4 : vpc) & ~32'h3;
    end else begin
      if (we && a2 == 5'd12) nsr = din & 32'h0000_fc03;
      if (we && a2 == 5'd14) nepc = din & ~32'h3;
      if (clr) nsr = nsr & ~32'h2;
    end
    m_sr    = nsr;
    m_cause = ncause;
    m_epc   = nepc;
  endtask

  task automatic step(input logic r, input logic [4:0] a1_v, input logic [4:0] a2_v,
                      input logic [31:0] din_v, input logic we_v, input logic [31:0] vpc_v,
                      input logic bd_v, input logic [4:0] exc_v, input logic [5:0] hw_v,
                      input logic clr_v, input int lit_sel, input logic [31:0] lit);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    reset = r;   a1 = a1_v; a2 = a2_v; din = din_v; we = we_v;
    vpc = vpc_v; bd = bd_v; exc = exc_v; hw = hw_v; clr = clr_v;
    e.req = ((((hw & m_sr[15:10]) != 6'd0) && m_sr[0]) || (exc != 5'd0)) && !m_sr[1];
    case (a1)
      5'd12:   e.dout = m_sr;
      5'd13:   e.dout = m_cause;
      5'd14:   e.dout = m_epc;
      5'd15:   e.dout = PRID;
      default: e.dout = 32'd0;
    endcase
    e.epc_out = (we && a2 == 5'd14) ? (din & ~32'h3) : m_epc;
    e.lit_sel = lit_sel;
    e.lit     = lit;
    sbq.push_back(e);
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if (req !== e.req) begin
          errors++;
          $display("FAIL req: got %b want %b (t=%0t)", req, e.req, $time);
        end
        checks++;
        if (dout !== e.dout) begin
          errors++;
          $display("FAIL dout a1=%0d: got %h want %h (t=%0t)", a1, dout, e.dout, $time);
        end
        checks++;
        if (epc_out !== e.epc_out) begin
          errors++;
          $display("FAIL epc_out: got %h want %h (t=%0t)", epc_out, e.epc_out, $time);
        end
        if (e.lit_sel == 1) begin
          checks++;
          if (dout !== e.lit) begin
            errors++;
            $display("FAIL dout_lit a1=%0d: got %h want %h (t=%0t)", a1, dout, e.lit, $time);
          end
        end else if (e.lit_sel == 2) begin
          checks++;
          if (epc_out !== e.lit) begin
            errors++;
            $display("FAIL epc_lit: got %h want %h (t=%0t)", epc_out, e.lit, $time);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0; a1 = 5'd0; a2 = 5'd0; din = 32'd0; we = 1'b0;
    vpc = 32'd0;  bd = 1'b0; exc = 5'd0; hw = 6'h3f; clr = 1'b0;
    // Reset held across two edges with all interrupt lines high.
    step(0, 12, 0, 0, 0, 0, 0, 0, 6'h3f, 0, 1, 32'h0);
    step(1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    step(1, 13, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    step(1, 14, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    // Plain exception, then a second one masked by EXL.
    step(1, 15, 0, 0, 0, 32'h3008, 0, 10, 0, 0, 1, PRID);
    step(1, 13, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0028);
    step(1, 14, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_3008);
    step(1, 12, 0, 0, 0, 32'h3040, 0, 4, 0, 0, 1, 32'h0000_0002);
    step(1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0);
    // Delay-slot victim.
    step(1, 0, 0, 0, 0, 32'h3010, 1, 4, 0, 0, 0, 32'h0);
    step(1, 14, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_300c);
    step(1, 13, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0010);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
    // Interrupt beats a simultaneous exception; re-asserts after eret.
    step(1, 0, 12, 32'h0000_0401, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    step(1, 12, 0, 0, 0, 32'h3020, 0, 12, 6'h01, 0, 1, 32'h0000_0401);
    step(1, 13, 0, 0, 0, 0, 0, 0, 6'h01, 0, 1, 32'h0000_0400);
    step(1, 12, 0, 0, 0, 0, 0, 0, 6'h01, 1, 1, 32'h0000_0403);
    step(1, 12, 0, 0, 0, 32'h3024, 0, 0, 6'h01, 0, 1, 32'h0000_0401);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
    // Write rules.
    step(1, 0, 14, 32'h0000_4007, 1, 0, 0, 0, 0, 0, 2, 32'h0000_4004);
    step(1, 14, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_4004);
    step(1, 13, 13, 32'hffff_ffff, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    step(1, 13, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    step(1, 0, 14, 32'h0000_1234, 1, 32'h5000, 0, 3, 0, 0, 2, 32'h0000_1234);
    step(1, 14, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_5000);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
    step(1, 0, 12, 32'h0000_fc03, 1, 32'h6000, 0, 7, 0, 0, 0, 32'h0);
    step(1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0403);
    // mtc0 SR and eret together: write lands, then EXL clears.
    step(1, 0, 12, 32'h0000_0003, 1, 0, 0, 0, 0, 1, 0, 32'h0);
    step(1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0001);
    step(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic [4:0] ra1;
      logic [4:0] ra2;
      ra1 = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
      ra2 = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(12, 14));
      step(($urandom_range(0, 39) != 0), ra1, ra2, $urandom, ($urandom_range(0, 2) == 0),
           $urandom, 1'($urandom), ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom),
           6'($urandom), ($urandom_range(0, 3) == 0), 0, 32'h0);
    end

    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
